cacheline_adaptor: RTL and testbench



---
 rtl/cache_pkg.sv | 19 +
 rtl/cacheline_adaptor_if.sv | 33 +++
 rtl/cacheline_adaptor.sv | 81 ++++++++
 tb/tb_cacheline_adaptor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache-side constants and adaptor state type.
// Reused by the cache controller package.
package cache_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int ADDR_WIDTH  = 32;
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);

  typedef enum logic [2:0] {
    IDLE,
    RD_BURST,
    RD_DONE,
    WR_BURST,
    WR_DONE
  } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache-side and memory-side bus of the cacheline adaptor.
// master = adaptor view, slave = cache controller + memory view.
interface cacheline_adaptor_if;
  import cache_pkg::*;

  logic [LINE_WIDTH-1:0]  line_i;
  logic [LINE_WIDTH-1:0]  line_o;
  logic [ADDR_WIDTH-1:0]  address_i;
  logic                   read_i;
  logic                   write_i;
  logic                   resp_o;
  logic [BURST_WIDTH-1:0] burst_i;
  logic [BURST_WIDTH-1:0] burst_o;
  logic [ADDR_WIDTH-1:0]  address_o;
  logic                   read_o;
  logic                   write_o;
  logic                   resp_i;

  modport master (
    input  line_i, address_i, read_i, write_i,
    input  burst_i, resp_i,
    output line_o, resp_o, burst_o,
    output address_o, read_o, write_o
  );

  modport slave (
    output line_i, address_i, read_i, write_i,
    output burst_i, resp_i,
    input  line_o, resp_o, burst_o,
    input  address_o, read_o, write_o
  );

endinterface

// File: rtl/cacheline_adaptor.sv
// Splits 256-bit cacheline reads/write-backs into four
// 64-bit memory beats and returns a one-cycle line response.
module cacheline_adaptor
  import cache_pkg::*;
(
  input  logic clk,
  input  logic rst,
  cacheline_adaptor_if.master bus
);

  adaptor_state_t         r_state;
  adaptor_state_t         w_next;
  logic [1:0]             r_beat;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [LINE_WIDTH-1:0]  r_line;
  logic [ADDR_WIDTH-1:0]  w_aligned;
  logic                   w_bursting;
  logic                   w_last;
  int                     w_base;

  assign w_aligned = {bus.address_i[ADDR_WIDTH-1:OFFSET_BITS],
                      {OFFSET_BITS{1'b0}}};
  assign w_bursting = (r_state == RD_BURST) ||
                      (r_state == WR_BURST);
  assign w_last = bus.resp_i && (r_beat == 2'd3);
  assign w_base = int'(r_beat) * BURST_WIDTH;

  always_comb begin
    w_next        = r_state;
    bus.line_o    = r_line;
    bus.resp_o    = 1'b0;
    bus.burst_o   = '0;
    bus.address_o = '0;
    bus.read_o    = 1'b0;
    bus.write_o   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.write_i)     w_next = WR_BURST;
        else if (bus.read_i) w_next = RD_BURST;
      end
      RD_BURST: begin
        bus.read_o    = 1'b1;
        bus.address_o = r_addr;
        if (w_last) w_next = RD_DONE;
      end
      WR_BURST: begin
        bus.write_o   = 1'b1;
        bus.address_o = r_addr;
        bus.burst_o   = r_line[w_base +: BURST_WIDTH];
        if (w_last) w_next = WR_DONE;
      end
      RD_DONE, WR_DONE: begin
        bus.resp_o = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_addr  <= '0;
      r_line  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        if (bus.write_i || bus.read_i) r_addr <= w_aligned;
        if (bus.write_i) r_line <= bus.line_i;
      end
      if (w_bursting && bus.resp_i) begin
        if (r_state == RD_BURST)
          r_line[w_base +: BURST_WIDTH] <= bus.burst_i;
        // beat counter clears explicitly on the last beat
        r_beat <= (r_beat == 2'd3) ? 2'd0 : r_beat + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor with a transaction-level
// reference model compared after every clock edge.
module tb_cacheline_adaptor;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cacheline_adaptor_if bus ();

  cacheline_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // model: pending transaction + beats transferred so far
  bit          m_busy, m_wr, m_done;
  int          m_n;
  logic [31:0] m_addr;
  logic [255:0] m_line;

  task automatic chk(string name, logic [255:0] act,
                     logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    if (!rst) begin
      m_busy = 0; m_wr = 0; m_done = 0; m_n = 0;
      m_addr = '0; m_line = '0;
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (m_busy) begin
      if (bus.resp_i) begin
        if (!m_wr) m_line[m_n*64 +: 64] = bus.burst_i;
        m_n++;
        if (m_n == BEATS) begin m_done = 1; m_n = 0; end
      end
    end else if (bus.write_i || bus.read_i) begin
      m_busy = 1;
      m_wr   = bus.write_i;
      m_n    = 0;
      m_addr = bus.address_i & ~32'h1F;
      if (bus.write_i) m_line = bus.line_i;
    end
  endtask

  task automatic compare();
    bit act = m_busy && !m_done;
    chk("resp_o", 256'(bus.resp_o), 256'(m_done));
    chk("read_o", 256'(bus.read_o), 256'(act && !m_wr));
    chk("write_o", 256'(bus.write_o), 256'(act && m_wr));
    chk("address_o", 256'(bus.address_o),
        256'(act ? m_addr : 32'h0));
    chk("burst_o", 256'(bus.burst_o),
        256'((act && m_wr) ? m_line[m_n*64 +: 64] : 64'h0));
    chk("line_o", bus.line_o, m_line);
    if (bus.read_o && bus.write_o) chk("rd_wr_excl", 1, 0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  function automatic logic [63:0] pat(logic [7:0] b);
    return {8{b}};
  endfunction

  int rcnt;
  logic [255:0] wline;
  bit rs [7];

  initial begin
    bus.line_i = '0; bus.address_i = '0;
    bus.read_i = 0; bus.write_i = 0;
    bus.burst_i = '0; bus.resp_i = 0;
    m_busy = 0; m_wr = 0; m_done = 0; m_n = 0;
    m_addr = '0; m_line = '0;
    #1;
    tick(); tick();
    chk("rst_read_o", 256'(bus.read_o), 0);
    chk("rst_line_o", bus.line_o, 0);
    rst = 1;
    tick();

    // read without gaps; resp_o must land on cycle 6
    bus.read_i = 1; bus.address_i = 32'h0000_1234;
    rcnt = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c >= 2 && c <= 5) begin
        bus.resp_i = 1;
        bus.burst_i = pat(8'(8'h11 * (c - 1)));
      end else begin
        bus.resp_i = 0;
      end
      if (c == 2) chk("rd_addr_lit", 256'(bus.address_o),
                      256'(32'h0000_1220));
      if (c == 6) begin
        chk("rd_resp_lit", 256'(bus.resp_o), 1);
        chk("rd_read_low", 256'(bus.read_o), 0);
      end
      if (bus.resp_o) rcnt++;
      tick();
    end
    chk("rd_resp_once", 256'(rcnt), 1);
    chk("rd_line_lit", bus.line_o,
        {pat(8'h44), pat(8'h33), pat(8'h22), pat(8'h11)});
    // read_i was held through the resp cycle; drop it now
    bus.read_i = 0;
    tick();
    chk("b2b_no_reissue", 256'(bus.read_o), 0);
    tick();

    // write with gaps
    wline = {pat(8'hA3), pat(8'hA2), pat(8'hA1), pat(8'hA0)};
    bus.line_i = wline; bus.address_i = 32'h8000_003F;
    bus.write_i = 1;
    tick();
    bus.write_i = 0;
    bus.address_i = 32'hFFFF_FFFF;
    chk("wr_addr_lit", 256'(bus.address_o), 256'(32'h8000_0020));
    rs = '{1, 0, 1, 0, 0, 1, 1};
    rcnt = 0;
    for (int i = 0; i < 7; i++) begin
      chk("wr_beat_lit", 256'(bus.burst_o),
          256'(pat(8'(8'hA0 + rcnt))));
      bus.resp_i = rs[i];
      if (rs[i]) rcnt++;
      tick();
    end
    bus.resp_i = 0;
    chk("wr_resp_lit", 256'(bus.resp_o), 1);
    tick();
    chk("wr_idle", 256'(bus.resp_o), 0);

    // simultaneous read/write: write wins
    bus.read_i = 1; bus.write_i = 1; bus.address_i = 32'h40;
    tick();
    bus.read_i = 0; bus.write_i = 0;
    chk("prio_write_o", 256'(bus.write_o), 1);
    chk("prio_read_o", 256'(bus.read_o), 0);
    bus.resp_i = 1;
    repeat (4) tick();
    bus.resp_i = 0;
    tick();

    // reset mid-read after two beats, then a clean read
    bus.read_i = 1; bus.address_i = 32'h0000_0100;
    tick();
    bus.resp_i = 1; bus.burst_i = pat(8'h55);
    repeat (2) tick();
    bus.resp_i = 0; rst = 0;
    tick();
    rst = 1;
    chk("mid_rst_read", 256'(bus.read_o), 0);
    chk("mid_rst_resp", 256'(bus.resp_o), 0);
    chk("mid_rst_line", bus.line_o, 0);
    bus.read_i = 1; bus.address_i = 32'h0000_0200;
    for (int c = 1; c <= 6; c++) begin
      bus.resp_i = (c >= 2 && c <= 5);
      bus.burst_i = pat(8'(8'h60 + c));
      if (c == 6) chk("rerd_resp6", 256'(bus.resp_o), 1);
      if (c == 6) bus.read_i = 0;
      tick();
    end
    chk("rerd_line_lit", bus.line_o,
        {pat(8'h65), pat(8'h64), pat(8'h63), pat(8'h62)});

    // spurious resp_i in idle
    bus.resp_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("spur_resp_o", 256'(bus.resp_o), 0);
    end
    bus.resp_i = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
